sdf_stage_ctrl: RTL and testbench
=================================

Name: sdf_stage_ctrl

Overview:
- Sequencer for one radix-2 single-path delay-feedback (SDF) stage of the 64-point FFT pipeline.
- Drives the write/read enables of the stage's feedback FIFO.
- Selects butterfly mode (fill/pass vs compute) and generates the twiddle ROM address for the difference path.
- Handles frame alignment and an end-of-stream drain. Controls only; carries no sample data.

Parameters:
LOG2_DEPTH, 5, log2 of feedback delay length DEPTH = 2**LOG2_DEPTH; legal range 1..5
TW_SHIFT, 0, left shift applied to twiddle index; must equal 5-LOG2_DEPTH (32-entry W64 table)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream sample valid this cycle
in_sop  in  1  first sample of a 64-point frame; qualified by in_valid
flush  in  1  request drain of FIFO contents after final frame; level, sampled at frame boundary
fifo_w_en  out  1  feedback FIFO write enable
fifo_r_en  out  1  feedback FIFO read enable (FIFO read data is combinational on r_en)
bf_sel  out  1  0 = fill phase (input to FIFO, FIFO output to stage output); 1 = butterfly phase
tw_addr  out  5  twiddle ROM index for sample currently leaving stage
out_valid  out  1  stage output valid
out_sop  out  1  first output sample of a frame
busy  out  1  high in RUN or DRAIN
frame_err  out  1  one-cycle pulse on misaligned in_sop

Behaviour:
- Reset (async, rst_n low) clears all state, mid-operation included:
  - state=IDLE, cnt=0, primed=0.
  - All outputs 0.
- Registered state: 2-bit FSM, cnt [LOG2_DEPTH:0], primed flag. Outputs are combinational from registered state and in_valid (Mealy); zero added latency.
- Phase: ph = cnt[LOG2_DEPTH]. Index: k = cnt[LOG2_DEPTH-1:0].
- IDLE:
  - Outputs 0; samples without in_sop ignored.
  - in_valid&in_sop -> RUN; that sample is cnt=0.
- RUN, per valid sample (cnt += 1, wraps at 2*DEPTH):
  - fifo_w_en = in_valid.
  - ph=0: bf_sel=0; fifo_r_en = out_valid = in_valid&primed; tw_addr = k<<TW_SHIFT.
  - ph=1: bf_sel=1; fifo_r_en = out_valid = in_valid; tw_addr=0.
  - out_sop = out_valid & cnt==0 & primed, or out_valid & cnt==DEPTH & !primed.
  - At wrap from cnt=2*DEPTH-1: primed <= 1.
- in_valid low: counter, FIFO enables and outputs all hold 0/unchanged (bubbles pass through).
- Frame boundary is cnt==0 with primed=1 at the start of a cycle:
  - If flush=1 and no valid sample this cycle -> DRAIN.
  - A valid sample in the same cycle wins; flush is re-evaluated at the next boundary.
- DRAIN (exactly DEPTH cycles, cnt counts 0..DEPTH-1 each cycle regardless of in_valid):
  - fifo_w_en=0, fifo_r_en=1, out_valid=1, bf_sel=0, tw_addr=k<<TW_SHIFT; out_sop at k=0.
  - in_valid ignored.
  - On the last cycle -> IDLE, cnt=0, primed=0. FIFO read/write pointers end equal.
- In RUN, in_valid&in_sop with cnt!=0: frame_err pulses one cycle; sample processed as normal at the current cnt (no resync).
- Gap inside a frame: legal, no error.
- busy = (state!=IDLE).

Optional Feature:
- Macro SDF_FRAME_CHECK_EN.
- Defined: misaligned-sop detection as above, plus a second error case: in_sop absent at cnt==0 with primed=1 also pulses frame_err (counting continues).
- Undefined: no checking logic; frame_err tied 0.

Test Plan:
All scenarios use LOG2_DEPTH=2, TW_SHIFT=3.
- Reset then one frame of 8 valid samples, sop on first -> fifo_w_en 8 cycles; fifo_r_en/out_valid on samples 4..7 only, bf_sel=1 on those, out_sop on sample 4; primed=1 after.
- Second back-to-back frame -> samples 0..3: r_en=1, bf_sel=0, tw_addr=0,8,16,24, out_sop on sample 0; samples 4..7 as before.
- Bubbles: in_valid pattern 1,0,0,1 during ph=0 -> cnt advances only on valid cycles; enables 0 in bubbles.
- flush=1 at boundary after 2 frames, in_valid=0 -> DRAIN 4 cycles: r_en=1, w_en=0, tw_addr 0,8,16,24; then IDLE, busy=0.
- in_sop at cnt=3 -> frame_err one-cycle pulse, cnt continues to 4. With SDF_FRAME_CHECK_EN: missing sop at next boundary -> frame_err pulse.
- rst_n low mid-DRAIN at cycle 2 -> all outputs 0 immediately; next sop frame behaves as unprimed first frame.

Source files
------------

// File: rtl/sdf_stage_ctrl.sv
// Sequencer for one radix-2 SDF stage: FIFO enables, butterfly select, twiddle address.
// Optional frame checking is compiled in with `define SDF_FRAME_CHECK_EN.
module sdf_stage_ctrl #(
    parameter int LOG2_DEPTH = 5,
    parameter int TW_SHIFT   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       in_sop,
    input  logic       flush,
    output logic       fifo_w_en,
    output logic       fifo_r_en,
    output logic       bf_sel,
    output logic [4:0] tw_addr,
    output logic       out_valid,
    output logic       out_sop,
    output logic       busy,
    output logic       frame_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [LOG2_DEPTH:0] CNT_HALF = {1'b1, {LOG2_DEPTH{1'b0}}};
    localparam logic [LOG2_DEPTH:0] CNT_MAX  = {1'b1, {LOG2_DEPTH{1'b1}}};
    localparam logic [LOG2_DEPTH:0] CNT_DLST = {1'b0, {LOG2_DEPTH{1'b1}}};

    state_t                state;
    logic [LOG2_DEPTH:0]   cnt;
    logic                  primed;

    logic                  ph;
    logic [LOG2_DEPTH-1:0] k;
    logic [4:0]            tw_k;
    logic                  at_boundary;

    assign ph          = cnt[LOG2_DEPTH];
    assign k           = cnt[LOG2_DEPTH-1:0];
    assign tw_k        = 5'(k) << TW_SHIFT;
    assign at_boundary = (state == S_RUN) && (cnt == '0) && primed;
    assign busy        = (state != S_IDLE);

    // Mealy outputs from registered state plus the current input strobe
    always_comb begin
        fifo_w_en = 1'b0;
        fifo_r_en = 1'b0;
        bf_sel    = 1'b0;
        tw_addr   = '0;
        out_valid = 1'b0;
        out_sop   = 1'b0;
        frame_err = 1'b0;
        case (state)
            S_IDLE: begin
                // The starting sample is cnt=0 of an unprimed frame: write only
                fifo_w_en = in_valid & in_sop;
            end
            S_RUN: begin
                if (in_valid) begin
                    fifo_w_en = 1'b1;
                    if (!ph) begin
                        fifo_r_en = primed;
                        out_valid = primed;
                        tw_addr   = tw_k;
                    end else begin
                        bf_sel    = 1'b1;
                        fifo_r_en = 1'b1;
                        out_valid = 1'b1;
                    end
                    out_sop = out_valid & (((cnt == '0) & primed) |
                                           ((cnt == CNT_HALF) & ~primed));
`ifdef SDF_FRAME_CHECK_EN
                    frame_err = (in_sop & (cnt != '0)) |
                                (~in_sop & (cnt == '0) & primed);
`endif
                end
            end
            S_DRAIN: begin
                fifo_r_en = 1'b1;
                out_valid = 1'b1;
                tw_addr   = tw_k;
                out_sop   = (k == '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            primed <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_sop) begin
                        state <= S_RUN;
                        cnt   <= {{LOG2_DEPTH{1'b0}}, 1'b1};
                    end
                end
                S_RUN: begin
                    if (in_valid) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_MAX)
                            primed <= 1'b1;
                    end else if (at_boundary && flush) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Read out the DEPTH samples still held in the FIFO
                    if (cnt == CNT_DLST) begin
                        state  <= S_IDLE;
                        cnt    <= '0;
                        primed <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    cnt    <= '0;
                    primed <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Directed table-driven bench for sdf_stage_ctrl at LOG2_DEPTH=2, TW_SHIFT=3.
// Build with +define+SDF_FRAME_CHECK_EN to expect the extra frame_err pulses.
module tb_sdf_stage_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_sop, flush;
    logic       fifo_w_en, fifo_r_en, bf_sel, out_valid, out_sop, busy, frame_err;
    logic [4:0] tw_addr;

    int n_checks = 0;
    int n_errors = 0;

`ifdef SDF_FRAME_CHECK_EN
    localparam logic FC = 1'b1;
`else
    localparam logic FC = 1'b0;
`endif

    sdf_stage_ctrl #(.LOG2_DEPTH(2), .TW_SHIFT(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sop    (in_sop),
        .flush     (flush),
        .fifo_w_en (fifo_w_en),
        .fifo_r_en (fifo_r_en),
        .bf_sel    (bf_sel),
        .tw_addr   (tw_addr),
        .out_valid (out_valid),
        .out_sop   (out_sop),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        sop;
        logic        fl;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl[$];

    // Expected vector layout: {w_en, r_en, bf_sel, tw_addr[4:0], out_valid, out_sop, busy, frame_err}
    function automatic logic [11:0] pack(input logic w, r, bf, input logic [4:0] tw,
                                         input logic ov, os, bz, fe);
        return {w, r, bf, tw, ov, os, bz, fe};
    endfunction

    task automatic add(input logic v, sop, fl, w, r, bf, input logic [4:0] tw,
                       input logic ov, os, bz, fe);
        vec_t e;
        e.v = v; e.sop = sop; e.fl = fl;
        e.exp = pack(w, r, bf, tw, ov, os, bz, fe);
        tbl.push_back(e);
    endtask

    task automatic check(input string name, input logic [11:0] exp);
        logic [11:0] act;
        act = {fifo_w_en, fifo_r_en, bf_sel, tw_addr, out_valid, out_sop, busy, frame_err};
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %03h expected %03h (w r bf tw ov sop busy err)", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, sop, fl);
        @(negedge clk);
        in_valid = v;
        in_sop   = sop;
        flush    = fl;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sop = 1'b0; flush = 1'b0;

        // frame 1: unprimed
        add(1,1,0, 1,0,0,0, 0,0,0,0);
        add(1,0,0, 1,0,0,8, 0,0,1,0);
        add(1,0,0, 1,0,0,16,0,0,1,0);
        add(1,0,0, 1,0,0,24,0,0,1,0);
        add(1,0,0, 1,1,1,0, 1,1,1,0);
        for (int i = 0; i < 3; i++) add(1,0,0, 1,1,1,0, 1,0,1,0);
        // frame 2: primed, bubbles 1,0,0,1 in ph=0
        add(1,1,0, 1,1,0,0, 1,1,1,0);
        add(0,0,0, 0,0,0,0, 0,0,1,0);
        add(0,0,0, 0,0,0,0, 0,0,1,0);
        add(1,0,0, 1,1,0,8, 1,0,1,0);
        add(1,0,0, 1,1,0,16,1,0,1,0);
        add(1,0,0, 1,1,0,24,1,0,1,0);
        for (int i = 0; i < 4; i++) add(1,0,0, 1,1,1,0, 1,0,1,0);
        // frame 3: misaligned sop at cnt=3
        add(1,1,0, 1,1,0,0, 1,1,1,0);
        add(1,0,0, 1,1,0,8, 1,0,1,0);
        add(1,0,0, 1,1,0,16,1,0,1,0);
        add(1,1,0, 1,1,0,24,1,0,1,FC);
        for (int i = 0; i < 4; i++) add(1,0,0, 1,1,1,0, 1,0,1,0);
        // frame 4: flush with valid at boundary loses, sop missing, flush on mid-frame bubble
        add(1,0,1, 1,1,0,0, 1,1,1,FC);
        add(1,0,0, 1,1,0,8, 1,0,1,0);
        add(1,0,0, 1,1,0,16,1,0,1,0);
        add(1,0,0, 1,1,0,24,1,0,1,0);
        add(1,0,0, 1,1,1,0, 1,0,1,0);
        add(0,0,1, 0,0,0,0, 0,0,1,0);
        for (int i = 0; i < 3; i++) add(1,0,0, 1,1,1,0, 1,0,1,0);
        // boundary bubble without flush, then with flush
        add(0,0,0, 0,0,0,0, 0,0,1,0);
        add(0,0,1, 0,0,0,0, 0,0,1,0);
        // drain: inputs ignored
        add(1,1,0, 0,1,0,0, 1,1,1,0);
        add(1,0,0, 0,1,0,8, 1,0,1,0);
        add(0,0,0, 0,1,0,16,1,0,1,0);
        add(1,1,1, 0,1,0,24,1,0,1,0);
        // back in idle: sample without sop ignored
        add(0,0,0, 0,0,0,0, 0,0,0,0);
        add(1,0,0, 0,0,0,0, 0,0,0,0);

        #1;
        check("reset", 12'h000);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].sop, tbl[i].fl);
            check($sformatf("row%0d", i), tbl[i].exp);
        end

        // two frames, drain, asynchronous reset in drain cycle 2
        drive(1,1,0);
        check("seq_s0", pack(1,0,0,0, 0,0,0,0));
        for (int i = 1; i < 16; i++) drive(1,0,0);
        drive(0,0,1);
        check("seq_flush", pack(0,0,0,0, 0,0,1,0));
        drive(0,0,0);
        drive(0,0,0);
        drive(0,0,0);
        check("seq_drain2", pack(0,1,0,16, 1,0,1,0));
        rst_n = 1'b0;
        #1;
        check("seq_async_rst", 12'h000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("seq_post_rst", 12'h000);

        // frame after reset must behave unprimed
        drive(1,1,0);
        check("unprimed_s0", pack(1,0,0,0, 0,0,0,0));
        drive(1,0,0);
        check("unprimed_s1", pack(1,0,0,8, 0,0,1,0));
        drive(1,0,0);
        drive(1,0,0);
        drive(1,0,0);
        check("unprimed_s4", pack(1,1,1,0, 1,1,1,0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
